// File: rtl/pifo_axis_rx_checker.sv
// Receive-side AXI4-Stream sink for the PIFO path: drives tready (optionally LFSR-throttled),
// checks framing, tkeep, tuser stability and rank ordering, and keeps traffic statistics.
module pifo_axis_rx_checker #(
  parameter int unsigned DATA_WIDTH      = 256,
  parameter int unsigned SUME_META_WIDTH = 168,
  parameter int unsigned KEEP_WIDTH      = DATA_WIDTH / 8,
  parameter int unsigned RANK_LSB        = 0,
  parameter int unsigned RANK_WIDTH      = 16,
  parameter int unsigned IDLE_LIMIT      = 1000,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]      s_axis_tkeep,
  input  logic [SUME_META_WIDTH-1:0] s_axis_tuser,
  input  logic                       s_axis_tvalid,
  input  logic                       s_axis_tlast,
  output logic                       s_axis_tready,
  input  logic                       bp_enable,
  input  logic                       order_clear,
  output logic [31:0]                pkt_count,
  output logic [31:0]                beat_count,
  output logic [47:0]                byte_count,
  output logic                       err_order,
  output logic                       err_tuser,
  output logic                       err_keep,
  output logic [15:0]                err_count,
  output logic [RANK_WIDTH-1:0]      last_rank,
  output logic                       idle_done
);

  localparam int unsigned POP_W  = $clog2(KEEP_WIDTH) + 1;
  localparam int unsigned IDLE_W = 32;

  typedef enum logic [0:0] {
    WAIT_SOP = 1'b0,
    IN_PKT   = 1'b1
  } state_t;

  state_t                     state;
  logic [15:0]                lfsr;
  logic [15:0]                lfsr_nxt;
  logic [SUME_META_WIDTH-1:0] cap_tuser;
  logic [RANK_WIDTH-1:0]      cap_rank;
  logic                       pkt_seen;
  logic                       clear_arm;
  logic [IDLE_W-1:0]          idle_cnt;
  logic [IDLE_W-1:0]          idle_nxt;

  logic                       accept;
  logic [RANK_WIDTH-1:0]      beat_rank;
  logic [POP_W-1:0]           keep_bytes;
  logic [KEEP_WIDTH-1:0]      keep_inc;
  logic                       keep_ok;
  logic                       order_armed;
  logic                       v_order;
  logic                       v_tuser;
  logic                       v_keep;
  logic [1:0]                 err_inc;
  logic [16:0]                err_sum;
  logic [15:0]                err_nxt;
  logic                       unused_data;

  // Payload bytes are never inspected; only framing and sideband are checked.
  assign unused_data = ^s_axis_tdata;

  assign accept    = s_axis_tvalid && s_axis_tready;
  assign beat_rank = s_axis_tuser[RANK_LSB +: RANK_WIDTH];
  assign lfsr_nxt  = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  assign keep_inc  = s_axis_tkeep + KEEP_WIDTH'(1);

  always_comb begin
    keep_bytes = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      keep_bytes = keep_bytes + POP_W'(s_axis_tkeep[i]);
    end
  end

  // Last beat may be partial but must be a nonzero run of bytes anchored at byte 0.
  always_comb begin
    keep_ok = 1'b0;
    if (s_axis_tlast) begin
      keep_ok = (s_axis_tkeep != '0) && ((s_axis_tkeep & keep_inc) == '0);
    end else begin
      keep_ok = (s_axis_tkeep == '1);
    end
  end

  always_comb begin
    order_armed = clear_arm || order_clear;
    v_order     = accept && (state == WAIT_SOP) && pkt_seen && !order_armed
                  && (beat_rank < last_rank);
    v_tuser     = accept && (state == IN_PKT) && (s_axis_tuser != cap_tuser);
    v_keep      = accept && !keep_ok;
    err_inc     = 2'(v_order) + 2'(v_tuser) + 2'(v_keep);
    err_sum     = {1'b0, err_count} + 17'(err_inc);
    err_nxt     = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  always_comb begin
    idle_nxt = idle_cnt;
    if (accept) begin
      idle_nxt = '0;
    end else if (pkt_seen && (idle_cnt != '1)) begin
      idle_nxt = idle_cnt + IDLE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= WAIT_SOP;
      lfsr          <= LFSR_SEED;
      s_axis_tready <= 1'b0;
      cap_tuser     <= '0;
      cap_rank      <= '0;
      pkt_seen      <= 1'b0;
      clear_arm     <= 1'b0;
      idle_cnt      <= '0;
      pkt_count     <= '0;
      beat_count    <= '0;
      byte_count    <= '0;
      err_order     <= 1'b0;
      err_tuser     <= 1'b0;
      err_keep      <= 1'b0;
      err_count     <= '0;
      last_rank     <= '0;
      idle_done     <= 1'b0;
    end else begin
      lfsr          <= lfsr_nxt;
      s_axis_tready <= bp_enable ? lfsr_nxt[0] : 1'b1;
      idle_cnt      <= idle_nxt;
      if (order_clear) begin
        clear_arm <= 1'b1;
      end
      if (!accept && pkt_seen && (idle_nxt == IDLE_W'(IDLE_LIMIT))) begin
        idle_done <= 1'b1;
      end

      if (accept) begin
        beat_count <= beat_count + 32'(1);
        byte_count <= byte_count + 48'(keep_bytes);
        case (state)
          WAIT_SOP: begin
            clear_arm <= 1'b0;
            if (s_axis_tlast) begin
              pkt_count <= pkt_count + 32'(1);
              last_rank <= beat_rank;
              pkt_seen  <= 1'b1;
            end else begin
              state     <= IN_PKT;
              cap_tuser <= s_axis_tuser;
              cap_rank  <= beat_rank;
            end
          end
          IN_PKT: begin
            if (s_axis_tlast) begin
              state     <= WAIT_SOP;
              pkt_count <= pkt_count + 32'(1);
              last_rank <= cap_rank;
              pkt_seen  <= 1'b1;
            end
          end
          default: state <= WAIT_SOP;
        endcase
      end

      if (v_order) err_order <= 1'b1;
      if (v_tuser) err_tuser <= 1'b1;
      if (v_keep)  err_keep  <= 1'b1;
      err_count <= err_nxt;
    end
  end

endmodule

// File: tb/tb_pifo_axis_rx_checker.sv
// Scoreboard bench for pifo_axis_rx_checker: expected packet ranks are queued as beats are
// driven and popped when pkt_count advances; counters and flags are checked per scenario.
module tb_pifo_axis_rx_checker;

  localparam int unsigned DW = 256;
  localparam int unsigned UW = 168;
  localparam int unsigned KW = DW / 8;
  localparam int unsigned RW = 16;
  localparam logic [15:0] SEED = 16'hACE1;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic [UW-1:0] s_axis_tuser;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic          s_axis_tready;
  logic          bp_enable;
  logic          order_clear;
  logic [31:0]   pkt_count;
  logic [31:0]   beat_count;
  logic [47:0]   byte_count;
  logic          err_order;
  logic          err_tuser;
  logic          err_keep;
  logic [15:0]   err_count;
  logic [RW-1:0] last_rank;
  logic          idle_done;

  int checks = 0;
  int errors = 0;

  logic [RW-1:0] rank_q[$];
  logic [31:0]   exp_pkt;
  logic [31:0]   exp_beat;
  logic [47:0]   exp_byte;
  logic          in_pkt;
  logic [RW-1:0] cur_rank;
  logic          chk_tready;
  logic [15:0]   m_lfsr;
  logic [31:0]   prev_pkt;

  pifo_axis_rx_checker dut (
    .clk           (clk),
    .reset         (reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .bp_enable     (bp_enable),
    .order_clear   (order_clear),
    .pkt_count     (pkt_count),
    .beat_count    (beat_count),
    .byte_count    (byte_count),
    .err_order     (err_order),
    .err_tuser     (err_tuser),
    .err_keep      (err_keep),
    .err_count     (err_count),
    .last_rank     (last_rank),
    .idle_done     (idle_done)
  );

  always #5 clk = ~clk;

  // Reference backpressure LFSR: Fibonacci, taps 16,14,13,11, shifting toward bit 0.
  always @(posedge clk) begin
    if (reset) m_lfsr <= SEED;
    else       m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
  end

  // Scoreboard consumer: every new completed packet must match the oldest queued rank.
  always @(negedge clk) begin
    if (!reset && (pkt_count != prev_pkt)) begin
      checks++;
      if (rank_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: pkt_count=%0d with no expected packet queued", pkt_count);
      end else begin
        logic [RW-1:0] r;
        r = rank_q.pop_front();
        if (last_rank !== r) begin
          errors++;
          $display("FAIL last_rank: got %0d expected %0d (pkt_count=%0d)", last_rank, r, pkt_count);
        end
      end
    end
    prev_pkt = pkt_count;
  end

  function automatic logic [UW-1:0] mk_user(input logic [RW-1:0] rank, input logic [7:0] tag);
    logic [UW-1:0] u;
    u          = '0;
    u[RW-1:0]  = rank;
    u[107:100] = tag;
    return u;
  endfunction

  // Presents one beat and waits for it to be accepted; expectations are updated on acceptance.
  task automatic send_beat(input logic [KW-1:0] keep, input logic [UW-1:0] user, input logic last);
    logic acc;
    int   n;
    for (int i = 0; i < DW / 32; i++) s_axis_tdata[i*32 +: 32] = $urandom;
    s_axis_tkeep  = keep;
    s_axis_tuser  = user;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    if (!in_pkt) cur_rank = user[RW-1:0];
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 500) begin
      if (chk_tready) begin
        checks++;
        if (s_axis_tready !== m_lfsr[0]) begin
          errors++;
          $display("FAIL bp_tready: got %b expected lfsr[0]=%b", s_axis_tready, m_lfsr[0]);
        end
      end
      acc = s_axis_tready;
      if (acc) begin
        exp_beat++;
        exp_byte += 48'($countones(keep));
        if (last) begin
          exp_pkt++;
          rank_q.push_back(cur_rank);
          in_pkt = 1'b0;
        end else begin
          in_pkt = 1'b1;
        end
      end
      @(negedge clk);
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: beat not accepted within %0d cycles", n);
    end
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset         = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    bp_enable     = 1'b0;
    order_clear   = 1'b0;
    chk_tready    = 1'b0;
    repeat (2) @(negedge clk);
    rank_q.delete();
    exp_pkt  = '0;
    exp_beat = '0;
    exp_byte = '0;
    in_pkt   = 1'b0;
    reset    = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_counts(input string tag);
    checks++;
    if ({pkt_count, beat_count, byte_count} !== {exp_pkt, exp_beat, exp_byte}) begin
      errors++;
      $display("FAIL %s counts: got pkt=%0d beat=%0d byte=%0d expected pkt=%0d beat=%0d byte=%0d",
               tag, pkt_count, beat_count, byte_count, exp_pkt, exp_beat, exp_byte);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    s_axis_tvalid = 1'b0;
    bp_enable = 1'b0;
    order_clear = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (s_axis_tready !== 1'b0) begin
      errors++;
      $display("FAIL reset_tready: got %b expected 0", s_axis_tready);
    end
    checks++;
    if ({pkt_count, beat_count, byte_count, err_count, last_rank,
         err_order, err_tuser, err_keep, idle_done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: pkt=%0d beat=%0d byte=%0d err=%0d rank=%0d flags=%b%b%b%b expected all 0",
               pkt_count, beat_count, byte_count, err_count, last_rank,
               err_order, err_tuser, err_keep, idle_done);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (s_axis_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_tready: got %b expected 1", s_axis_tready);
    end
  endtask

  task automatic test_basic();
    do_reset();
    send_beat('1, mk_user(5, 0), 1'b0);
    send_beat('1, mk_user(5, 0), 1'b1);
    send_beat(32'h0000_00FF, mk_user(5, 1), 1'b1);
    send_beat('1, mk_user(9, 2), 1'b0);
    send_beat('1, mk_user(9, 2), 1'b0);
    send_beat('1, mk_user(9, 2), 1'b1);
    idle(2);
    checks++;
    if ({pkt_count, beat_count, byte_count} !== {32'd3, 32'd6, 48'd168}) begin
      errors++;
      $display("FAIL basic_counts: got pkt=%0d beat=%0d byte=%0d expected 3 6 168",
               pkt_count, beat_count, byte_count);
    end
    checks++;
    if ({err_order, err_tuser, err_keep, err_count} !== '0) begin
      errors++;
      $display("FAIL basic_errors: got flags=%b%b%b count=%0d expected none",
               err_order, err_tuser, err_keep, err_count);
    end
    checks++;
    if (last_rank !== 16'd9) begin
      errors++;
      $display("FAIL basic_last_rank: got %0d expected 9", last_rank);
    end
  endtask

  task automatic test_order();
    do_reset();
    send_beat('1, mk_user(10, 0), 1'b1);
    send_beat('1, mk_user(4, 0), 1'b1);
    idle(1);
    checks++;
    if ({err_order, err_count} !== {1'b1, 16'd1}) begin
      errors++;
      $display("FAIL order_violation: got err_order=%b err_count=%0d expected 1 1", err_order, err_count);
    end
    order_clear = 1'b1;
    @(negedge clk);
    order_clear = 1'b0;
    idle(3);
    send_beat('1, mk_user(2, 0), 1'b1);
    send_beat('1, mk_user(3, 0), 1'b1);
    idle(1);
    checks++;
    if (err_count !== 16'd1) begin
      errors++;
      $display("FAIL order_clear: got err_count=%0d expected 1", err_count);
    end
    send_beat('1, mk_user(1, 0), 1'b1);
    idle(1);
    checks++;
    if (err_count !== 16'd2) begin
      errors++;
      $display("FAIL order_clear_oneshot: got err_count=%0d expected 2", err_count);
    end
    check_counts("order");
  endtask

  task automatic test_keep_tuser();
    do_reset();
    send_beat(32'h7FFF_FFFF, mk_user(0, 0), 1'b0);
    send_beat('1, mk_user(0, 0), 1'b1);
    idle(1);
    checks++;
    if ({err_keep, err_tuser, err_count} !== {1'b1, 1'b0, 16'd1}) begin
      errors++;
      $display("FAIL keep_nonlast: got err_keep=%b err_tuser=%b err_count=%0d expected 1 0 1",
               err_keep, err_tuser, err_count);
    end
    send_beat(32'h0000_00F0, mk_user(0, 0), 1'b1);
    idle(1);
    checks++;
    if (err_count !== 16'd2) begin
      errors++;
      $display("FAIL keep_last: got err_count=%0d expected 2", err_count);
    end
    send_beat('1, mk_user(0, 3), 1'b0);
    send_beat('1, mk_user(0, 4), 1'b0);
    send_beat(32'h0000_0001, mk_user(0, 3), 1'b1);
    idle(1);
    checks++;
    if ({err_tuser, err_order, err_count} !== {1'b1, 1'b0, 16'd3}) begin
      errors++;
      $display("FAIL tuser_change: got err_tuser=%b err_order=%b err_count=%0d expected 1 0 3",
               err_tuser, err_order, err_count);
    end
    // Same beat breaks both tuser and tkeep rules: both are counted.
    send_beat('1, mk_user(0, 7), 1'b0);
    send_beat('0, mk_user(0, 8), 1'b1);
    idle(1);
    checks++;
    if (err_count !== 16'd5) begin
      errors++;
      $display("FAIL double_violation: got err_count=%0d expected 5", err_count);
    end
    check_counts("keep_tuser");
  endtask

  task automatic test_backpressure();
    do_reset();
    bp_enable = 1'b1;
    @(negedge clk);
    chk_tready = 1'b1;
    for (int i = 0; i < 20; i++) send_beat('1, mk_user(RW'(i), 0), 1'b1);
    chk_tready = 1'b0;
    idle(1);
    bp_enable = 1'b0;
    checks++;
    if ({pkt_count, beat_count} !== {32'd20, 32'd20}) begin
      errors++;
      $display("FAIL bp_counts: got pkt=%0d beat=%0d expected 20 20", pkt_count, beat_count);
    end
    check_counts("backpressure");
    checks++;
    if (err_count !== 16'd0) begin
      errors++;
      $display("FAIL bp_errors: got err_count=%0d expected 0", err_count);
    end
  endtask

  task automatic test_idle();
    int n;
    do_reset();
    send_beat(32'h0000_000F, mk_user(1, 0), 1'b1);
    idle(999);
    checks++;
    if (idle_done !== 1'b0) begin
      errors++;
      $display("FAIL idle_early: got idle_done=%b expected 0 at idle cycle 999", idle_done);
    end
    send_beat(32'h0000_000F, mk_user(1, 0), 1'b1);
    s_axis_tvalid = 1'b0;
    n = 0;
    while (!idle_done && n < 1200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 1000) begin
      errors++;
      $display("FAIL idle_limit: got idle_done after %0d cycles expected 1000", n);
    end
    send_beat('1, mk_user(1, 0), 1'b1);
    idle(1);
    checks++;
    if (idle_done !== 1'b1) begin
      errors++;
      $display("FAIL idle_sticky: got idle_done=%b expected 1", idle_done);
    end
    check_counts("idle");
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_beat('1, mk_user(6, 0), 1'b0);
    reset = 1'b1;
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    checks++;
    if ({s_axis_tready, pkt_count, beat_count, byte_count, err_count, last_rank} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got tready=%b pkt=%0d beat=%0d byte=%0d err=%0d rank=%0d expected all 0",
               s_axis_tready, pkt_count, beat_count, byte_count, err_count, last_rank);
    end
    @(negedge clk);
    rank_q.delete();
    exp_pkt = '0;
    exp_beat = '0;
    exp_byte = '0;
    in_pkt = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    send_beat(32'h0000_0003, mk_user(7, 0), 1'b1);
    idle(1);
    checks++;
    if ({pkt_count, beat_count, byte_count, err_count} !== {32'd1, 32'd1, 48'd2, 16'd0}) begin
      errors++;
      $display("FAIL reset_mid_next: got pkt=%0d beat=%0d byte=%0d err=%0d expected 1 1 2 0",
               pkt_count, beat_count, byte_count, err_count);
    end
  endtask

  initial begin
    reset         = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tuser  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    bp_enable     = 1'b0;
    order_clear   = 1'b0;
    chk_tready    = 1'b0;
    in_pkt        = 1'b0;
    cur_rank      = '0;
    exp_pkt       = '0;
    exp_beat      = '0;
    exp_byte      = '0;
    prev_pkt      = '0;

    test_reset();
    test_basic();
    test_order();
    test_keep_tuser();
    test_backpressure();
    test_idle();
    test_reset_mid();

    checks++;
    if (rank_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected packets never completed", rank_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pifo_axis_rx_checker.md
Name: pifo_axis_rx_checker

Overview:
- Receive-side end of the PIFO AXI4-Stream path; the counterpart of the stimulus transmitter that feeds PIFO_MODULE.
- Consumes m_axis from PIFO_MODULE and drives tready, optionally with pseudo-random backpressure.
- Checks framing, tkeep legality, tuser stability and PIFO rank ordering, and keeps packet/beat/byte counters.
- Asserts a done flag after a programmable number of idle cycles following the first packet; this flag is the simulation stop condition.

Parameters:
DATA_WIDTH, 256, tdata width in bits (multiple of 8)
SUME_META_WIDTH, 168, tuser width
KEEP_WIDTH, DATA_WIDTH/8, tkeep width
RANK_LSB, 0, lsb of the rank field in tuser
RANK_WIDTH, 16, rank field width
IDLE_LIMIT, 1000, idle cycles after the last accepted beat before done
LFSR_SEED, 16'hACE1, nonzero reset value of the backpressure LFSR

Ports:
clk  in  1  single clock; all logic on the rising edge
reset  in  1  synchronous, active-high
s_axis_tdata  in  DATA_WIDTH  stream data
s_axis_tkeep  in  KEEP_WIDTH  byte enables
s_axis_tuser  in  SUME_META_WIDTH  metadata; rank at [RANK_LSB +: RANK_WIDTH]
s_axis_tvalid  in  1  beat valid
s_axis_tlast  in  1  last beat of packet
s_axis_tready  out  1  sink ready
bp_enable  in  1  1 = gate tready with the LFSR
order_clear  in  1  pulse; next packet's rank is not order-checked
pkt_count  out  32  packets completed
beat_count  out  32  beats accepted
byte_count  out  48  bytes accepted (popcount of tkeep)
err_order  out  1  sticky; a rank decrease was seen
err_tuser  out  1  sticky; tuser changed inside a packet
err_keep  out  1  sticky; illegal tkeep
err_count  out  16  total violations, saturating at 16'hFFFF
last_rank  out  RANK_WIDTH  rank of the most recent packet
idle_done  out  1  sticky; idle limit reached

Behaviour:
- Reset (synchronous, active-high):
  - All counters, error flags, idle_done, last_rank and state clear to 0.
  - LFSR loads LFSR_SEED.
  - s_axis_tready is 0 during reset and goes high in the first cycle after reset deasserts.
  - Reset mid-packet discards the partial packet; no count or error is recorded for it.
- tready:
  - bp_enable=0: tready=1 whenever not in reset.
  - bp_enable=1: tready=lfsr[0].
  - LFSR is 16-bit Fibonacci, taps 16,14,13,11, and advances every cycle regardless of bp_enable.
- Accept: a beat is accepted when tvalid && tready. Nothing else is sampled or counted.
- FSM states WAIT_SOP, IN_PKT; transitions occur only on accepted beats.
  - WAIT_SOP, accept, tlast=0 -> IN_PKT. Capture tuser (held for the packet) and the rank.
  - WAIT_SOP, accept, tlast=1 -> stay in WAIT_SOP. Single-beat packet.
  - IN_PKT, accept, tlast=1 -> WAIT_SOP.
- Per accepted beat:
  - beat_count += 1.
  - byte_count += popcount(tkeep), computed over a width of log2(KEEP_WIDTH)+1.
  - Counters wrap modulo 2^width.
- On an accepted tlast beat: pkt_count += 1 and last_rank <= the captured rank.
- Rank order check, performed on the first beat of each packet:
  - Violation if rank < last_rank (unsigned) and at least one packet has completed since reset.
  - Not checked for the first packet after reset, nor for the first packet after an order_clear pulse.
  - The order_clear arm persists until that packet starts.
  - Equal ranks are legal.
- tuser check: in IN_PKT, any accepted beat whose tuser differs from the captured tuser is a violation.
- tkeep check:
  - Non-last beat: tkeep must be all ones.
  - Last beat: tkeep must be a nonzero contiguous run starting at bit 0, i.e. (tkeep & (tkeep+1)) == 0 and tkeep != 0.
- Error reporting:
  - Each violation sets its sticky flag in the cycle after the beat and adds 1 to err_count.
  - Multiple violations on the same beat add their sum.
  - err_count saturates at 16'hFFFF.
  - Errors never stall or alter acceptance.
- Idle logic:
  - A 32-bit idle counter clears on every accepted beat.
  - It increments on other cycles only once at least one packet has completed.
  - idle_done sets when the counter reaches IDLE_LIMIT and stays set until reset.
  - A beat accepted after idle_done still updates counters but does not clear idle_done.
- tvalid held high with tready low: no state change, no check.
- All outputs are registered; statistics are visible 1 cycle after the accepting edge.

Test Plan:
- 3 packets, bp_enable=0:
  - Packet A: 2 beats, rank 5. Packet B: 1 beat, rank 5, tkeep=32'h0000_00FF. Packet C: 3 beats, rank 9.
  - Required: pkt_count=3, beat_count=6, byte_count=5*32+8=168, no errors, last_rank=9.
- Rank order violation:
  - Ranks 10 then 4 -> err_order=1, err_count=1.
  - Then pulse order_clear and send ranks 2 then 3 -> err_count stays 1.
- Framing/keep/tuser violations:
  - Non-last beat with tkeep=32'h7FFF_FFFF -> err_keep=1.
  - Last beat with tkeep=32'h0000_00F0 -> err_count increments again.
  - tuser changes on beat 2 of a 3-beat packet -> err_tuser=1.
- Backpressure:
  - bp_enable=1, source holds tvalid high with 20 single-beat packets.
  - Required: tready follows lfsr[0]; exactly 20 beats are counted; no duplicates and no loss.
  - Compare counts against a reference model of the same LFSR.
- Idle done, IDLE_LIMIT=1000:
  - After the last beat, idle_done rises exactly 1000 cycles later.
  - A beat at idle cycle 999 restarts the count.
- Reset mid-packet:
  - Assert reset after beat 1 of a 3-beat packet.
  - Required: all outputs return to 0, tready is low during reset, and the next clean packet is counted as pkt_count=1.
